// File: rtl/sram_1rw_ctrl_if.sv
// Requester-side bus of sram_1rw_ctrl: two identical command/response
// channels (A and B) sharing one single-port SRAM.
//   a_vld/b_vld     command valid
//   a_we/b_we       1 = write, 0 = read
//   a_addr/b_addr   entry index
//   a_wdata/b_wdata write data
//   a_rdy/b_rdy     command accepted this cycle
//   a_rsp_vld/...   read data valid (one cycle after acceptance)
//   a_rsp_data/...  read data
// master: requester side, slave: controller side.
interface sram_1rw_ctrl_if #(
    parameter int W = 32,
    parameter int N = 256
);
    localparam int AW = $clog2(N);

    logic          a_vld;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [W-1:0]  a_wdata;
    logic          a_rdy;
    logic          a_rsp_vld;
    logic [W-1:0]  a_rsp_data;

    logic          b_vld;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [W-1:0]  b_wdata;
    logic          b_rdy;
    logic          b_rsp_vld;
    logic [W-1:0]  b_rsp_data;

    modport master (
        output a_vld, a_we, a_addr, a_wdata,
        input  a_rdy, a_rsp_vld, a_rsp_data,
        output b_vld, b_we, b_addr, b_wdata,
        input  b_rdy, b_rsp_vld, b_rsp_data
    );

    modport slave (
        input  a_vld, a_we, a_addr, a_wdata,
        output a_rdy, a_rsp_vld, a_rsp_data,
        input  b_vld, b_we, b_addr, b_wdata,
        output b_rdy, b_rsp_vld, b_rsp_data
    );
endinterface

// File: rtl/sram_1rw_ctrl.sv
// Controller and round-robin arbiter for one single-port (1RW) SRAM macro.
// After reset every entry is written with INIT_VALUE (N cycles), then the
// port is shared between requesters A and B, one command per cycle.
//   clk        clock, all state on posedge
//   rst        synchronous active-high reset
//   req        requester bus (sram_1rw_ctrl_if.slave), channels A and B
//   init_done  high once initialisation is complete
//   sram_addr  SRAM address
//   sram_din   SRAM write data
//   sram_cs_n  SRAM chip select, active low
//   sram_we_n  SRAM write enable, active low (1 = read)
//   sram_dout  SRAM registered read data
module sram_1rw_ctrl #(
    parameter int          W          = 32,
    parameter int          N          = 256,
    parameter logic [W-1:0] INIT_VALUE = '0,
    localparam int         AW         = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    sram_1rw_ctrl_if.slave  req,
    output logic            init_done,
    output logic [AW-1:0]   sram_addr,
    output logic [W-1:0]    sram_din,
    output logic            sram_cs_n,
    output logic            sram_we_n,
    input  logic [W-1:0]    sram_dout
);
    typedef enum logic {INIT, RUN} state_t;

    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_t        state, state_nx;
    logic [AW-1:0] cnt;
    logic          ptr_b;      // 1: B wins the next tie, 0: A wins
    logic          a_rsp_q, b_rsp_q;
    logic          grant_a, grant_b;

    // State register plus the datapath registers that follow it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            cnt     <= '0;
            ptr_b   <= 1'b0;
            a_rsp_q <= 1'b0;
            b_rsp_q <= 1'b0;
        end else begin
            state <= state_nx;
            // Counter parks at the last entry so it never exceeds N-1.
            if (state == INIT && cnt != LAST)
                cnt <= cnt + 1'b1;
            if (grant_a)
                ptr_b <= 1'b1;
            else if (grant_b)
                ptr_b <= 1'b0;
            a_rsp_q <= grant_a & ~req.a_we;
            b_rsp_q <= grant_b & ~req.b_we;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        if (state == INIT && cnt == LAST)
            state_nx = RUN;
    end

    // Outputs: init write sweep, or arbitration and SRAM drive.
    always_comb begin
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        req.a_rdy = 1'b0;
        req.b_rdy = 1'b0;
        sram_cs_n = 1'b1;
        sram_we_n = 1'b1;
        sram_addr = '0;
        sram_din  = '0;
        unique case (state)
            INIT: begin
                sram_cs_n = 1'b0;
                sram_we_n = 1'b0;
                sram_addr = cnt;
                sram_din  = INIT_VALUE;
            end
            RUN: begin
                grant_a   = req.a_vld & (~req.b_vld | ~ptr_b);
                grant_b   = req.b_vld & ~grant_a;
                req.a_rdy = grant_a;
                req.b_rdy = grant_b;
                if (grant_a) begin
                    sram_cs_n = 1'b0;
                    sram_we_n = ~req.a_we;
                    sram_addr = req.a_addr;
                    sram_din  = req.a_wdata;
                end else if (grant_b) begin
                    sram_cs_n = 1'b0;
                    sram_we_n = ~req.b_we;
                    sram_addr = req.b_addr;
                    sram_din  = req.b_wdata;
                end
            end
            default: ;
        endcase
    end

    assign init_done      = (state == RUN);
    assign req.a_rsp_vld  = a_rsp_q;
    assign req.b_rsp_vld  = b_rsp_q;
    // Read data comes straight from the SRAM's output register.
    assign req.a_rsp_data = sram_dout;
    assign req.b_rsp_data = sram_dout;
endmodule

// File: tb/tb_sram_1rw_ctrl.sv
module tb_sram_1rw_ctrl;
    localparam int          W    = 32;
    localparam int          N    = 16;
    localparam int          AW   = $clog2(N);
    localparam logic [W-1:0] INIT = 32'h0000_00A5;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_done;
    logic [AW-1:0] sram_addr;
    logic [W-1:0]  sram_din;
    logic          sram_cs_n;
    logic          sram_we_n;
    logic [W-1:0]  sram_dout;

    int compared   = 0;
    int mismatched = 0;

    sram_1rw_ctrl_if #(.W(W), .N(N)) bus ();

    sram_1rw_ctrl #(.W(W), .N(N), .INIT_VALUE(INIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (bus),
        .init_done (init_done),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_cs_n (sram_cs_n),
        .sram_we_n (sram_we_n),
        .sram_dout (sram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM macro with registered read data.
    logic [W-1:0] mem [N];
    always @(posedge clk) begin
        if (sram_cs_n === 1'b0) begin
            if (sram_we_n === 1'b0) mem[sram_addr] <= sram_din;
            else                    sram_dout      <= mem[sram_addr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles since reset, tie preference, expected contents,
    // and the one-deep response expected from each requester.
    int           m_cyc;
    bit           seen_rst = 0;
    bit           m_pref_b;
    bit           m_pa, m_pb;
    logic [W-1:0] m_da, m_db;
    logic [W-1:0] ref_mem [N];

    always @(negedge clk) begin
        bit           ea, eb, ecs, ewe, edone;
        logic [AW-1:0] eaddr;
        logic [W-1:0]  edin;
        if (rst) begin
            seen_rst = 1;
            m_cyc    = 0;
            m_pref_b = 0;
            m_pa     = 0;
            m_pb     = 0;
        end else if (seen_rst) begin
            ea = 0; eb = 0; ecs = 1; ewe = 1; eaddr = '0; edin = '0;
            if (m_cyc < N) begin
                edone = 0; ecs = 0; ewe = 0;
                eaddr = AW'(m_cyc); edin = INIT;
            end else begin
                edone = 1;
                ea = bus.a_vld && !(bus.b_vld && m_pref_b);
                eb = bus.b_vld && !ea;
                if (ea) begin
                    ecs = 0; ewe = !bus.a_we; eaddr = bus.a_addr; edin = bus.a_wdata;
                end else if (eb) begin
                    ecs = 0; ewe = !bus.b_we; eaddr = bus.b_addr; edin = bus.b_wdata;
                end
            end
            chk("init_done", 64'(init_done), 64'(edone));
            chk("a_rdy", 64'(bus.a_rdy), 64'(ea));
            chk("b_rdy", 64'(bus.b_rdy), 64'(eb));
            chk("sram_cs_n", 64'(sram_cs_n), 64'(ecs));
            chk("sram_we_n", 64'(sram_we_n), 64'(ewe));
            chk("sram_addr", 64'(sram_addr), 64'(eaddr));
            chk("sram_din", 64'(sram_din), 64'(edin));
            chk("a_rsp_vld", 64'(bus.a_rsp_vld), 64'(m_pa));
            chk("b_rsp_vld", 64'(bus.b_rsp_vld), 64'(m_pb));
            if (m_pa) chk("a_rsp_data", 64'(bus.a_rsp_data), 64'(m_da));
            if (m_pb) chk("b_rsp_data", 64'(bus.b_rsp_data), 64'(m_db));
            // advance to the state after the coming edge
            if (m_cyc < N) begin
                ref_mem[m_cyc] = INIT;
                m_pa = 0;
                m_pb = 0;
                m_cyc++;
            end else begin
                m_pa = ea && !bus.a_we;
                m_pb = eb && !bus.b_we;
                if (ea) m_da = ref_mem[bus.a_addr];
                if (eb) m_db = ref_mem[bus.b_addr];
                if (ea && bus.a_we) ref_mem[bus.a_addr] = bus.a_wdata;
                if (eb && bus.b_we) ref_mem[bus.b_addr] = bus.b_wdata;
                if (ea)      m_pref_b = 1;
                else if (eb) m_pref_b = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.a_vld = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_vld = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
    endtask

    task automatic run_init_literal(input string tag);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk({tag, "_addr"}, 64'(sram_addr), 64'(i));
            chk({tag, "_busy"}, 64'(init_done), 64'd0);
            tick();
        end
        @(negedge clk);
        chk({tag, "_done"}, 64'(init_done), 64'd1);
    endtask

    initial begin
        logic [W-1:0] exp_d;
        rst = 1;
        idle();
        tick(); tick();
        rst = 0;

        // A requests a read during INIT: held off, served once RUN starts.
        bus.a_vld = 1; bus.a_we = 0; bus.a_addr = 4'd7;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk("init_addr", 64'(sram_addr), 64'(i));
            chk("init_din", 64'(sram_din), 64'h0000_00A5);
            chk("init_holdoff", 64'(bus.a_rdy), 64'd0);
            tick();
        end
        @(negedge clk);
        chk("init_done_16", 64'(init_done), 64'd1);
        chk("first_grant", 64'(bus.a_rdy), 64'd1);
        tick();
        idle();
        @(negedge clk);
        chk("rd7_vld", 64'(bus.a_rsp_vld), 64'd1);
        chk("rd7_data", 64'(bus.a_rsp_data), 64'h0000_00A5);
        tick();

        // Write by A, read-after-write by B.
        bus.a_vld = 1; bus.a_we = 1; bus.a_addr = 4'd3; bus.a_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("wr3_rdy", 64'(bus.a_rdy), 64'd1);
        tick();
        idle();
        bus.b_vld = 1; bus.b_we = 0; bus.b_addr = 4'd3;
        @(negedge clk);
        chk("rd3_rdy", 64'(bus.b_rdy), 64'd1);
        tick();
        idle();
        @(negedge clk);
        chk("raw_vld", 64'(bus.b_rsp_vld), 64'd1);
        chk("raw_data", 64'(bus.b_rsp_data), 64'hDEADBEEF);
        chk("raw_a_quiet", 64'(bus.a_rsp_vld), 64'd0);
        tick();

        // Both requesters contend: strict alternation starting with A.
        bus.a_vld = 1; bus.a_addr = 4'd3;
        bus.b_vld = 1; bus.b_addr = 4'd7;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_a", 64'(bus.a_rdy), 64'((i % 2) == 0));
            chk("rr_b", 64'(bus.b_rdy), 64'((i % 2) == 1));
            tick();
        end
        idle();

        // Back-to-back reads from A, addresses 0..4.
        for (int i = 0; i < 6; i++) begin
            if (i < 5) begin bus.a_vld = 1; bus.a_addr = AW'(i); end
            else idle();
            @(negedge clk);
            if (i < 5) chk("b2b_rdy", 64'(bus.a_rdy), 64'd1);
            if (i > 0) begin
                exp_d = (i - 1 == 3) ? 32'hDEADBEEF : 32'h0000_00A5;
                chk("b2b_vld", 64'(bus.a_rsp_vld), 64'd1);
                chk("b2b_data", 64'(bus.a_rsp_data), 64'(exp_d));
            end
            tick();
        end

        // Reset at INIT counter 5: full N-cycle sweep restarts from 0.
        rst = 1; tick(); rst = 0;
        repeat (5) tick();
        rst = 1; tick(); rst = 0;
        run_init_literal("reinit");
        tick();

        // Reset right after a read is accepted: the response is dropped.
        bus.a_vld = 1; bus.a_addr = 4'd1;
        @(negedge clk);
        chk("pre_rst_rdy", 64'(bus.a_rdy), 64'd1);
        tick();
        idle();
        rst = 1; tick(); rst = 0;
        @(negedge clk);
        chk("rst_drop", 64'(bus.a_rsp_vld), 64'd0);
        repeat (N) tick();

        // Pointer back at A after reset.
        bus.a_vld = 1; bus.b_vld = 1;
        @(negedge clk);
        chk("ptr_rst_a", 64'(bus.a_rdy), 64'd1);
        tick();
        @(negedge clk);
        chk("ptr_rst_b", 64'(bus.b_rdy), 64'd1);
        tick();
        bus.b_vld = 0;
        tick();
        // Idle keeps the pointer: B was passed over last, so B goes first.
        idle();
        @(negedge clk);
        chk("idle_cs", 64'(sram_cs_n), 64'd1);
        chk("idle_we", 64'(sram_we_n), 64'd1);
        tick(); tick();
        bus.a_vld = 1; bus.b_vld = 1;
        @(negedge clk);
        chk("ptr_hold_b", 64'(bus.b_rdy), 64'd1);
        chk("ptr_hold_a", 64'(bus.a_rdy), 64'd0);
        tick();
        idle();

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            rst          = ($urandom_range(0, 299) == 0);
            bus.a_vld    = $urandom_range(0, 2) != 0;
            bus.a_we     = $urandom_range(0, 1) == 1;
            bus.a_addr   = AW'($urandom_range(0, N - 1));
            bus.a_wdata  = $urandom;
            bus.b_vld    = $urandom_range(0, 2) != 0;
            bus.b_we     = $urandom_range(0, 1) == 1;
            bus.b_addr   = AW'($urandom_range(0, N - 1));
            bus.b_wdata  = $urandom;
            tick();
        end
        rst = 0;
        idle();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
